vx_kmu_dispatch: RTL
====================

# VX_kmu_dispatch

Block dispatcher downstream of the kernel management unit (KMU). It latches a kernel launch descriptor (PC, param pointer, 3-D grid and block dimensions) and walks the grid one thread block at a time. It issues each block as a task to one of `NUM_TARGETS` cores through rotating-priority valid/ready channels, counts completions, and pulses `done` when every issued block has retired.

## Interface
Parameters:
- `NUM_TARGETS`, default `` `NUM_CLUSTERS*`NUM_CORES ``: number of core task channels; ≥1.
- `NUM_THREADS`, default `` `NUM_THREADS ``: threads per warp; power of two.
- `OUT_W`, default 16: width of the outstanding-block counter.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: launch pulse; descriptor sampled this cycle.
- `pc`, in, `XLEN`: kernel entry PC.
- `param`, in, `XLEN`: kernel argument pointer.
- `grid_dim[2:0]`, in, 3×32: blocks per grid along x/y/z.
- `block_dim[2:0]`, in, 3×32: threads per block along x/y/z.
- `task_valid`, out, `NUM_TARGETS`: one-hot or zero; offers the current block to one target.
- `task_ready`, in, `NUM_TARGETS`: target can accept a block.
- `task_pc`, out, `XLEN`: latched PC.
- `task_param`, out, `XLEN`: latched param.
- `task_block_id[2:0]`, out, 3×32: block coordinates of the current offer.
- `task_num_warps`, out, 32: warps per block.
- `task_done`, in, `NUM_TARGETS`: one-cycle pulse per retired block, per target.
- `busy`, out, 1: state ≠ IDLE.
- `done`, out, 1: one-cycle pulse when the launch is complete.

## Operation
- **States:** IDLE → SETUP → DISPATCH → DRAIN → IDLE.
- **IDLE:** `start` latches the descriptor, clears block id to (0,0,0) and moves to SETUP. `start` in any other state is ignored.
- **SETUP** (1 cycle):
  - threads = bx·by·bz, truncated to 32 bits.
  - `task_num_warps` = ceil(threads / `NUM_THREADS`), computed by shift plus round-up of the low bits.
  - If any grid_dim or block_dim component is 0: go directly to IDLE and pulse `done` in the same transition. No `task_valid` is issued.
  - Otherwise go to DISPATCH.
- **DISPATCH:**
  - `task_valid[rr]` = 1, where `rr` is the rotating pointer; all other bits are 0.
  - If `task_ready[rr]`: transfer occurs. Block id increments with x fastest; x wraps to 0 and carries into y, y wraps and carries into z. `rr` advances.
  - If not ready: `rr` advances and the same block is offered to the next target next cycle. Offers are withdrawable.
  - On transfer of the last block (gx-1, gy-1, gz-1), go to DRAIN.
- **rr pointer:** wraps `NUM_TARGETS`-1 → 0. It resets to 0 and is not cleared between launches.
- **Outstanding counter:** +1 per transfer, −popcount(`task_done`) per cycle; both apply in the same cycle. It saturates at 0.
  - `task_done` when the counter is 0 is ignored.
  - A transfer when the counter is at max holds off: `task_valid` = 0 while counter = 2^OUT_W−1.
- **DRAIN:** when the counter is 0 (including the value after this cycle's update), go to IDLE with a `done` pulse.
- **Reset:** asynchronous reset at any time forces IDLE immediately. All outputs return to reset values; the in-flight launch is discarded and not resumed.

## Timing
- **Reset values:** `task_valid`=0, `busy`=0, `done`=0; `task_pc`, `task_param`, `task_block_id`, `task_num_warps` = 0; `rr`=0; counter=0.
- **Start latency:** `start` at cycle 0 gives SETUP in cycle 1 and the first `task_valid` in cycle 2.
- **Issue rate:** at most one block per cycle.
- **Next block visibility:** `task_block_id` updates the cycle after a transfer.
- **Done latency:** `done` asserts the cycle after the counter reaches 0 in DRAIN. `busy` drops in the same cycle as `done`.
- **Zero-dim launch:** `done` in cycle 2, `busy` high only in cycle 1.
- **Drive rule:** outputs are driven from registers. `task_valid` depends only on state, `rr` and the counter, never combinationally on `task_ready`.

## Test plan
- **Basic two-block launch:** grid (2,1,1), block (32,1,1), `NUM_THREADS`=4, 2 targets always ready. Required: cycle 2 target0 gets id (0,0,0) with `task_num_warps`=8; cycle 3 target1 gets (1,0,0). Pulse `task_done`=2'b11 in cycle 5 → `done` in cycle 6.
- **Wrap/carry order:** grid (2,2,2), one target always ready. Required: ids (0,0,0),(1,0,0),(0,1,0),(1,1,0),(0,0,1)…(1,1,1) on consecutive cycles, then DRAIN.
- **Round-up and stall skip:** block (33,1,1), `NUM_THREADS`=4 → `task_num_warps`=9. With target0 not ready and rr=0, required: the block goes to target1 the next cycle and target0 sees `task_valid` for exactly 1 cycle.
- **Zero dimension:** grid (3,0,1). Required: no `task_valid` ever; `done` pulses at cycle 2.
- **Simultaneous events:** transfer and `task_done` in the same cycle keep the counter unchanged. A second `start` during DISPATCH is ignored.
- **Reset mid-operation:** assert `reset` mid-DISPATCH. Required: `task_valid`=0 and `busy`=0 immediately, with no `done`. A new `start` afterwards restarts from (0,0,0) at target0.

Source files
------------

// File: rtl/vx_kmu_dispatch.sv
// Kernel block dispatcher: walks a 3-D grid of thread blocks and issues each one
// round-robin to a core task channel, then waits for every issued block to retire.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_CLUSTERS
`define NUM_CLUSTERS 1
`endif
`ifndef NUM_CORES
`define NUM_CORES 1
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

module vx_kmu_dispatch #(
  parameter int unsigned NUM_TARGETS = `NUM_CLUSTERS * `NUM_CORES,
  parameter int unsigned NUM_THREADS = `NUM_THREADS,
  parameter int unsigned OUT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [`XLEN-1:0]       pc,
  input  logic [`XLEN-1:0]       param,
  input  logic [31:0]            grid_dim [2:0],
  input  logic [31:0]            block_dim [2:0],
  output logic [NUM_TARGETS-1:0] task_valid,
  input  logic [NUM_TARGETS-1:0] task_ready,
  output logic [`XLEN-1:0]       task_pc,
  output logic [`XLEN-1:0]       task_param,
  output logic [31:0]            task_block_id [2:0],
  output logic [31:0]            task_num_warps,
  input  logic [NUM_TARGETS-1:0] task_done,
  output logic                   busy,
  output logic                   done
);
  localparam int unsigned RR_W    = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int unsigned POP_W   = $clog2(NUM_TARGETS + 1);
  localparam int unsigned SUM_W   = ((OUT_W > POP_W) ? OUT_W : POP_W) + 1;
  localparam int unsigned WARP_SH = $clog2(NUM_THREADS);

  typedef enum logic [1:0] {IDLE, SETUP, DISPATCH, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [RR_W-1:0]  rr_q, rr_d;
  logic [OUT_W-1:0] cnt_q, cnt_d;
  logic [`XLEN-1:0] pc_q, pc_d, param_q, param_d;
  logic [31:0]      grid_q [2:0], grid_d [2:0];
  logic [31:0]      blk_q [2:0], blk_d [2:0];
  logic [31:0]      bid_q [2:0], bid_d [2:0];
  logic [31:0]      warps_q, warps_d;
  logic             done_q, done_d;

  logic [31:0]      threads;
  logic             zero_dim, last_blk, xfer;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  always_comb begin
    threads  = blk_q[0] * blk_q[1] * blk_q[2];
    zero_dim = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (grid_q[i] == '0 || blk_q[i] == '0) zero_dim = 1'b1;
    end
    last_blk = (bid_q[0] == grid_q[0] - 32'd1) && (bid_q[1] == grid_q[1] - 32'd1) &&
               (bid_q[2] == grid_q[2] - 32'd1);

    // Offer withheld while the outstanding counter is saturated.
    task_valid = '0;
    if (state_q == DISPATCH && cnt_q != '1) task_valid = NUM_TARGETS'(1) << rr_q;
    xfer = |(task_valid & task_ready);

    pop = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) pop = pop + POP_W'(task_done[i]);
    sum   = SUM_W'(cnt_q) + SUM_W'(xfer);
    cnt_d = (sum > SUM_W'(pop)) ? OUT_W'(sum - SUM_W'(pop)) : '0;

    state_d = state_q;
    rr_d    = rr_q;
    pc_d    = pc_q;
    param_d = param_q;
    grid_d  = grid_q;
    blk_d   = blk_q;
    bid_d   = bid_q;
    warps_d = warps_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = pc;
          param_d = param;
          grid_d  = grid_dim;
          blk_d   = block_dim;
          bid_d   = '{default: '0};
          state_d = SETUP;
        end
      end
      SETUP: begin
        warps_d = (threads >> WARP_SH) + 32'((threads & 32'(NUM_THREADS - 1)) != '0);
        if (zero_dim) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        if (task_valid != '0) rr_d = (rr_q == RR_W'(NUM_TARGETS - 1)) ? '0 : rr_q + 1'b1;
        if (xfer) begin
          if (bid_q[0] != grid_q[0] - 32'd1) begin
            bid_d[0] = bid_q[0] + 32'd1;
          end else begin
            bid_d[0] = '0;
            if (bid_q[1] != grid_q[1] - 32'd1) begin
              bid_d[1] = bid_q[1] + 32'd1;
            end else begin
              bid_d[1] = '0;
              bid_d[2] = (bid_q[2] != grid_q[2] - 32'd1) ? bid_q[2] + 32'd1 : '0;
            end
          end
          if (last_blk) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      param_q <= '0;
      grid_q  <= '{default: '0};
      blk_q   <= '{default: '0};
      bid_q   <= '{default: '0};
      warps_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      param_q <= param_d;
      grid_q  <= grid_d;
      blk_q   <= blk_d;
      bid_q   <= bid_d;
      warps_q <= warps_d;
      done_q  <= done_d;
    end
  end

  assign task_pc        = pc_q;
  assign task_param     = param_q;
  assign task_block_id  = bid_q;
  assign task_num_warps = warps_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;

endmodule
